// File: rtl/demux2_stream_pkg.sv
// demux2_stream_pkg: channel select codes and slot state shared by the demux and its slots
package demux2_stream_pkg;
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;
endpackage

// File: rtl/stream_slot.sv
// stream_slot: one-entry valid/ready register slice with a wrapping delivered-byte counter
module stream_slot
    import demux2_stream_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_data,
    output logic                 valid,
    input  logic                 ready,
    output logic [WIDTH-1:0]     data,
    output logic [CNT_WIDTH-1:0] count
);
    slot_state_e state, state_nxt;
    always_ff @(posedge clk or negedge areset_n)
        if (!areset_n) state <= EMPTY;
        else state <= state_nxt;
    // a load always wins: the producer only loads when the slot is empty or draining
    always_comb begin
        state_nxt = state;
        state_nxt = load ? FULL : (state == FULL && ready) ? EMPTY : state;
    end
    assign valid = (state == FULL);
    always_ff @(posedge clk)
        if (load) data <= load_data;
    always_ff @(posedge clk or negedge areset_n)
        if (!areset_n) count <= '0;
        else if (valid && ready) count <= count + 1'b1;
endmodule

// File: rtl/demux2_stream.sv
// demux2_stream: 1-to-2 byte-stream demultiplexer; in_sel steers each accepted byte to slot A or B
module demux2_stream
    import demux2_stream_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sel,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic [WIDTH-1:0]     a_data,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [WIDTH-1:0]     b_data,
    output logic [CNT_WIDTH-1:0] a_count,
    output logic [CNT_WIDTH-1:0] b_count
);
    logic in_fire;
    // head-of-line: only the selected slot's readiness matters
    assign in_ready = (in_sel == SEL_B) ? (~b_valid | b_ready) : (~a_valid | a_ready);
    assign in_fire  = in_valid & in_ready;

    stream_slot #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_slot_a (
        .clk(clk), .areset_n(areset_n), .load(in_fire & (in_sel == SEL_A)), .load_data(in_data),
        .valid(a_valid), .ready(a_ready), .data(a_data), .count(a_count)
    );

    stream_slot #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_slot_b (
        .clk(clk), .areset_n(areset_n), .load(in_fire & (in_sel == SEL_B)), .load_data(in_data),
        .valid(b_valid), .ready(b_ready), .data(b_data), .count(b_count)
    );
endmodule

// File: doc/demux2_stream.md
# demux2_stream

Byte-stream 1-to-2 demultiplexer with valid/ready handshakes: the inverse of the team's 2:1 byte mux. Each accepted input byte is steered by `in_sel` into one of two output channels. A one-entry register slice per channel gives one cycle of latency and full throughput. Per-channel wrapping byte counters support debug and scoreboarding. The block sits between a shared producer and two independent consumers.

## Interface
- `WIDTH`, 8: data width in bits.
- `CNT_WIDTH`, 16: width of each per-channel delivered-byte counter.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `areset_n`, in, 1: asynchronous active-low reset; deassertion is synchronised externally.
- `in_valid`, in, 1: input byte present.
- `in_ready`, out, 1: block accepts the input byte this cycle.
- `in_data`, in, WIDTH: input byte.
- `in_sel`, in, 1: destination of the input byte; 0 routes to A, 1 routes to B.
- `a_valid`, out, 1: channel A holds a byte.
- `a_ready`, in, 1: channel A consumer accepts.
- `a_data`, out, WIDTH: channel A byte.
- `b_valid`, out, 1: channel B holds a byte.
- `b_ready`, in, 1: channel B consumer accepts.
- `b_data`, out, WIDTH: channel B byte.
- `a_count`, out, CNT_WIDTH: bytes delivered on A (counted on A handshake).
- `b_count`, out, CNT_WIDTH: bytes delivered on B (counted on B handshake).

## Operation
- Input handshake: `in_fire = in_valid & in_ready`.
- `in_ready = ~x_valid | x_ready`, where x is the channel chosen by `in_sel`.
  - `in_ready` is combinational from `in_sel`, `a_valid`/`b_valid` and `a_ready`/`b_ready`.
  - `in_ready` never depends on `in_valid`.
- Each channel is a one-entry slot with two states, EMPTY (valid=0) and FULL (valid=1).
  - EMPTY → FULL: on `in_fire` targeting this channel.
  - FULL → EMPTY: on output handshake with no new load.
  - FULL → FULL: output handshake and new load in the same cycle. The data register is replaced and the byte is not lost or duplicated.
  - FULL with no output handshake: the slot holds, and data/valid stay stable (AXI-style stability rule).
- Head-of-line blocking: when the selected channel is FULL and not ready, the input stalls even if the other channel is free. There is no reordering and no bypass.
- The non-selected channel drains independently of the input.
- Counters: each counter increments by 1 on its output handshake and wraps modulo 2^CNT_WIDTH.
- Data registers are loaded only on `in_fire`, so they need no reset.
- Reset values: `a_valid=0`, `b_valid=0`, `a_count=0`, `b_count=0`. After reset `in_ready=1`, because both slots are EMPTY.
- Reset mid-operation: any buffered bytes are discarded, and the counters clear asynchronously.

## Timing
- Latency: a byte accepted at edge N appears on `x_valid`/`x_data` right after edge N, and is consumable in cycle N+1.
- Throughput: 1 byte/cycle sustained to either channel, or alternating, while consumers hold ready=1.
- `in_sel` and `in_data` are sampled only on `in_fire`. When `in_valid=0` they are don't-care.
- Valid/ready combinational path: `x_ready` → `in_ready` (one mux level). There is no path from `in_valid` to any ready.
- The counter update is visible the cycle after the output handshake edge.

## Structure
- A shared package holds the `SEL_A=1'b0` and `SEL_B=1'b1` constants and the slot state enum {EMPTY, FULL}.
- One natural sub-module, `stream_slot`: a one-entry register slice with load/valid/ready and its own counter, instantiated twice.
- The top level holds only the `in_sel` decode and the `in_ready` mux.

## Test plan
- Reset, then idle: `a_valid`/`b_valid`=0, counts=0, `in_ready`=1.
- Alternating, consumers always ready: send 0xaa sel=0, 0xbb sel=1, 0xaa sel=0 on consecutive cycles.
  - A receives 0xaa, 0xaa, one cycle after each accept.
  - B receives 0xbb.
  - Final counts: a_count=2, b_count=1.
- Back-pressure on A: hold `a_ready=0` and send 0xff sel=0, then 0x00 sel=0.
  - 0xff is held on A.
  - `in_ready`=0 while `in_sel`=0.
  - Send 0x00 sel=1: it is accepted and delivered on B.
  - Release `a_ready`: 0xff is delivered once, and a_count=1.
- Simultaneous drain and load: A FULL with 0x11, `a_ready=1`, input 0x22 sel=0.
  - Next cycle A shows 0x22, valid stays 1, and a_count increments by 1.
- Counter wrap: with CNT_WIDTH=4, deliver 17 bytes to B → b_count=1.
- Async reset mid-stream: assert `areset_n=0` between edges while both slots are FULL.
  - Valids drop to 0 immediately and counts read 0.
  - The first post-reset byte 0x5a sel=1 is delivered on B with b_count=1.
